// File: rtl/pipe_exec_core.sv
`default_nettype none
// =============================================================================
// pipe_exec_core : issue/EX/MEM/WB datapath slice with register file,
//                  hazard stalls, branch resolution and optional forwarding.
// Build option   : define PIPE_FWD_EN to enable EX operand forwarding.
// Revision       : 1.0  initial release
// =============================================================================
module pipe_exec_core #(
  parameter  int W     = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_valid_i,
  output logic          inst_ready_o,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic [AW-1:0] rd_i,
  input  logic [W-1:0]  imm_i,
  input  logic [W-1:0]  pc_i,
  input  logic [2:0]    alu_op_i,
  input  logic          use_imm_i,
  input  logic          reg_write_i,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic          branch_i,
  input  logic          bne_i,
  output logic [W-1:0]  mem_addr_o,
  output logic [W-1:0]  mem_wdata_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  input  logic [W-1:0]  mem_rdata_i,
  output logic          br_taken_o,
  output logic [W-1:0]  br_target_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [W-1:0]  wb_data_o
);

  localparam int SW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;

  logic [W-1:0]  rf_q [NREGS];

  logic          ex_valid_q, ex_use_imm_q, ex_rw_q, ex_mr_q, ex_mw_q, ex_br_q, ex_bne_q;
  logic [AW-1:0] ex_rd_q;
  logic [W-1:0]  ex_imm_q, ex_pc_q, ex_a_q, ex_b_q;
  logic [2:0]    ex_op_q;
`ifdef PIPE_FWD_EN
  logic [AW-1:0] ex_rs1_q, ex_rs2_q;
`endif

  logic          mem_valid_q, mem_rw_q, mem_mr_q, mem_mw_q;
  logic [AW-1:0] mem_rd_q;
  logic [W-1:0]  mem_alu_q, mem_wdata_q;

  logic          wb_valid_q, wb_rw_q, wb_mr_q;
  logic [AW-1:0] wb_rd_q;
  logic [W-1:0]  wb_alu_q;

  logic          uses_rs2, hazard, accept;
  logic [W-1:0]  rs1_val, rs2_val, op_a, op_b, alu_b, alu_res;
  logic [SW-1:0] shamt;

  // Write-back port and memory strobes
  assign wb_we_o     = wb_valid_q && wb_rw_q && (wb_rd_q != '0);
  assign wb_addr_o   = wb_rd_q;
  assign wb_data_o   = wb_mr_q ? mem_rdata_i : wb_alu_q;
  assign mem_we_o    = mem_valid_q && mem_mw_q;
  assign mem_re_o    = mem_valid_q && mem_mr_q;
  assign mem_addr_o  = mem_alu_q;
  assign mem_wdata_o = mem_wdata_q;

  // Issue-stage register read; a WB write in the same cycle is seen immediately
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_i != '0) rs1_val = (wb_we_o && (wb_addr_o == rs1_i)) ? wb_data_o : rf_q[rs1_i];
    if (rs2_i != '0) rs2_val = (wb_we_o && (wb_addr_o == rs2_i)) ? wb_data_o : rf_q[rs2_i];
  end

  assign uses_rs2 = !use_imm_i || mem_write_i || branch_i;

  always_comb begin
    hazard = 1'b0;
`ifdef PIPE_FWD_EN
    // Only a load in EX cannot be forwarded in time
    if (ex_valid_q && ex_mr_q && (ex_rd_q != '0) &&
        ((ex_rd_q == rs1_i) || (uses_rs2 && (ex_rd_q == rs2_i))))
      hazard = 1'b1;
`else
    if (ex_valid_q && ex_rw_q && (ex_rd_q != '0) &&
        ((ex_rd_q == rs1_i) || (uses_rs2 && (ex_rd_q == rs2_i))))
      hazard = 1'b1;
    if (mem_valid_q && mem_rw_q && (mem_rd_q != '0) &&
        ((mem_rd_q == rs1_i) || (uses_rs2 && (mem_rd_q == rs2_i))))
      hazard = 1'b1;
`endif
  end

  assign inst_ready_o = !br_taken_o && !(inst_valid_i && hazard);
  assign accept       = inst_valid_i && inst_ready_o;

  always_comb begin
    op_a = ex_a_q;
    op_b = ex_b_q;
`ifdef PIPE_FWD_EN
    if (mem_valid_q && mem_rw_q && !mem_mr_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q))
      op_a = mem_alu_q;
    else if (wb_we_o && (wb_addr_o == ex_rs1_q))
      op_a = wb_data_o;
    if (mem_valid_q && mem_rw_q && !mem_mr_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q))
      op_b = mem_alu_q;
    else if (wb_we_o && (wb_addr_o == ex_rs2_q))
      op_b = wb_data_o;
`endif
  end

  assign alu_b = ex_use_imm_q ? ex_imm_q : op_b;
  assign shamt = alu_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (ex_op_q)
      OP_ADD:  alu_res = op_a + alu_b;
      OP_SUB:  alu_res = op_a - alu_b;
      OP_AND:  alu_res = op_a & alu_b;
      OP_OR:   alu_res = op_a | alu_b;
      OP_XOR:  alu_res = op_a ^ alu_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      default: alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
    endcase
  end

  assign br_taken_o  = ex_valid_q && ex_br_q && (ex_bne_q ? (op_a != op_b) : (op_a == op_b));
  assign br_target_o = ex_pc_q + ex_imm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we_o) begin
      rf_q[wb_addr_o] <= wb_data_o;
    end
  end

  // ID/EX: fields follow the issue port every cycle, the valid bit marks acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_use_imm_q <= 1'b0;
      ex_rw_q      <= 1'b0;
      ex_mr_q      <= 1'b0;
      ex_mw_q      <= 1'b0;
      ex_br_q      <= 1'b0;
      ex_bne_q     <= 1'b0;
      ex_rd_q      <= '0;
      ex_imm_q     <= '0;
      ex_pc_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_op_q      <= '0;
`ifdef PIPE_FWD_EN
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
`endif
    end else begin
      ex_valid_q   <= accept;
      ex_use_imm_q <= use_imm_i;
      ex_rw_q      <= reg_write_i;
      ex_mr_q      <= mem_read_i;
      ex_mw_q      <= mem_write_i;
      ex_br_q      <= branch_i;
      ex_bne_q     <= bne_i;
      ex_rd_q      <= rd_i;
      ex_imm_q     <= imm_i;
      ex_pc_q      <= pc_i;
      ex_a_q       <= rs1_val;
      ex_b_q       <= rs2_val;
      ex_op_q      <= alu_op_i;
`ifdef PIPE_FWD_EN
      ex_rs1_q     <= rs1_i;
      ex_rs2_q     <= rs2_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      mem_mw_q    <= 1'b0;
      mem_rd_q    <= '0;
      mem_alu_q   <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_mr_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_alu_q    <= '0;
    end else begin
      mem_valid_q <= ex_valid_q && !br_taken_o;
      mem_rw_q    <= ex_rw_q;
      mem_mr_q    <= ex_mr_q;
      mem_mw_q    <= ex_mw_q;
      mem_rd_q    <= ex_rd_q;
      mem_alu_q   <= alu_res;
      mem_wdata_q <= op_b;
      wb_valid_q  <= mem_valid_q;
      wb_rw_q     <= mem_rw_q;
      wb_mr_q     <= mem_valid_q && mem_mr_q;
      wb_rd_q     <= mem_rd_q;
      wb_alu_q    <= mem_alu_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_exec_core.sv
`default_nettype none
// =============================================================================
// tb_pipe_exec_core : random + directed stimulus against an in-order ISA model.
// Revision          : 1.0  initial release
// =============================================================================
module tb_pipe_exec_core;

  localparam int W     = 16;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inst_valid_i, inst_ready_o;
  logic [AW-1:0] rs1_i, rs2_i, rd_i;
  logic [W-1:0]  imm_i, pc_i;
  logic [2:0]    alu_op_i;
  logic          use_imm_i, reg_write_i, mem_read_i, mem_write_i, branch_i, bne_i;
  logic [W-1:0]  mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic          mem_we_o, mem_re_o, br_taken_o, wb_we_o;
  logic [W-1:0]  br_target_o, wb_data_o;
  logic [AW-1:0] wb_addr_o;

  always #5 clk = ~clk;

  pipe_exec_core #(.W(W), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .imm_i(imm_i), .pc_i(pc_i),
    .alu_op_i(alu_op_i), .use_imm_i(use_imm_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .branch_i(branch_i), .bne_i(bne_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
    .mem_rdata_i(mem_rdata_i), .br_taken_o(br_taken_o), .br_target_o(br_target_o),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  typedef struct {
    logic [AW-1:0] rs1, rs2, rd;
    logic [W-1:0]  imm, pc;
    logic [2:0]    op;
    logic          use_imm, rw, mr, mw, br, bne;
  } instr_t;
  typedef struct { int cyc; logic [W-1:0] a; logic [W-1:0] d; } ev_t;
  typedef struct { bit v; logic [AW-1:0] rd; bit rw; bit mr; } hist_t;

  ev_t          q_wb[$], q_st[$], q_ld[$], q_br[$];
  hist_t        h1, h2;
  logic [W-1:0] m_reg [NREGS];
  logic [W-1:0] m_mem [16];
  logic [W-1:0] d_mem [16];
  instr_t       cur, dir_q[$];
  bit           cur_v, last_acc_mw;
  int           cyc, n_chk, n_err;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    sh = int'(b) % W;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
  endfunction

  // Architectural execution at acceptance; pipeline effects are scheduled by latency
  task automatic model_issue(input instr_t i);
    logic [W-1:0] a, b, ob, r, v, rdw;
    a  = (i.rs1 == 0) ? '0 : m_reg[i.rs1];
    b  = (i.rs2 == 0) ? '0 : m_reg[i.rs2];
    ob = i.use_imm ? i.imm : b;
    r  = ref_alu(i.op, a, ob);
    v  = r;
    if (i.br && (i.bne ? (a != b) : (a == b))) q_br.push_back('{cyc + 1, '0, i.pc + i.imm});
    if (i.mw) begin
      q_st.push_back('{cyc + 2, r, b});
      m_mem[r[3:0]] = b;
    end
    if (i.mr) begin
      q_ld.push_back('{cyc + 2, r, '0});
      v = m_mem[r[3:0]];
    end
    if (i.rw && i.rd != 0) begin
      m_reg[i.rd] = v;
      rdw = '0;
      rdw[AW-1:0] = i.rd;
      q_wb.push_back('{cyc + 3, rdw, v});
    end
  endtask

  function automatic bit reads(input hist_t h, input instr_t i);
    bit uses2;
    uses2 = !i.use_imm || i.mw || i.br;
    return h.v && (h.rd != 0) && ((h.rd == i.rs1) || (uses2 && (h.rd == i.rs2)));
  endfunction

  function automatic instr_t mk(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                                input logic [W-1:0] imm, input bit ui, input bit rw);
    instr_t i;
    i.op = op; i.rd = AW'(rd); i.rs1 = AW'(rs1); i.rs2 = AW'(rs2);
    i.imm = imm; i.pc = '0; i.use_imm = ui; i.rw = rw;
    i.mr = 1'b0; i.mw = 1'b0; i.br = 1'b0; i.bne = 1'b0;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    logic [31:0] x, y;
    int k;
    x = $urandom; y = $urandom;
    i = mk(3'($urandom_range(0, 7)), $urandom_range(0, 5), $urandom_range(0, 4),
           $urandom_range(0, 4), '0, 1'($urandom_range(0, 1)), 1'b0);
    i.imm = ($urandom_range(0, 3) == 0) ? x[W-1:0] : W'($urandom_range(0, 20));
    i.pc  = y[W-1:0];
    i.bne = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 99);
    if (k < 55) i.rw = 1'b1;
    else if (k < 70) begin i.mr = 1'b1; i.rw = 1'b1; i.op = 3'd0; i.use_imm = 1'b1; end
    else if (k < 82) begin i.mw = 1'b1; i.op = 3'd0; i.use_imm = 1'b1; end
    else if (k < 94) begin i.br = 1'b1; i.use_imm = 1'b0; end
    return i;
  endfunction

  task automatic next_instr();
    if (dir_q.size() > 0) begin
      cur = dir_q.pop_front();
      cur_v = 1'b1;
    end else begin
      cur = rand_instr();
      cur_v = ($urandom_range(0, 9) != 0);
    end
    inst_valid_i = cur_v; rs1_i = cur.rs1; rs2_i = cur.rs2; rd_i = cur.rd;
    imm_i = cur.imm; pc_i = cur.pc; alu_op_i = cur.op; use_imm_i = cur.use_imm;
    reg_write_i = cur.rw; mem_read_i = cur.mr; mem_write_i = cur.mw;
    branch_i = cur.br; bne_i = cur.bne;
  endtask

  task automatic step();
    bit exp_tk, exp_st, exp_ld, exp_wb, haz, acc, s_we, s_re;
    logic [W-1:0] s_addr, s_wd;
    logic [31:0] junk;
    hist_t hn;
    @(negedge clk);
    exp_tk = (q_br.size() > 0) && (q_br[0].cyc == cyc);
`ifdef PIPE_FWD_EN
    haz = h1.mr && reads(h1, cur);
`else
    haz = (h1.rw && reads(h1, cur)) || (h2.rw && reads(h2, cur));
`endif
    haz = cur_v && haz;
    chk("inst_ready", inst_ready_o, !exp_tk && !haz);
    chk("br_taken", br_taken_o, exp_tk);
    if (exp_tk) chk("br_target", br_target_o, q_br.pop_front().d);
    exp_st = (q_st.size() > 0) && (q_st[0].cyc == cyc);
    exp_ld = (q_ld.size() > 0) && (q_ld[0].cyc == cyc);
    exp_wb = (q_wb.size() > 0) && (q_wb[0].cyc == cyc);
    chk("mem_we", mem_we_o, exp_st);
    chk("mem_re", mem_re_o, exp_ld);
    chk("wb_we", wb_we_o, exp_wb);
    if (exp_st) begin
      chk("st_addr", mem_addr_o, q_st[0].a);
      chk("st_data", mem_wdata_o, q_st[0].d);
      void'(q_st.pop_front());
    end
    if (exp_ld) chk("ld_addr", mem_addr_o, q_ld.pop_front().a);
    if (exp_wb) begin
      chk("wb_addr", W'(wb_addr_o), q_wb[0].a);
      chk("wb_data", wb_data_o, q_wb[0].d);
      void'(q_wb.pop_front());
    end
    acc = cur_v && !exp_tk && !haz;
    last_acc_mw = acc && cur.mw;
    hn = '{1'b0, '0, 1'b0, 1'b0};
    if (acc) begin
      model_issue(cur);
      hn = '{1'b1, cur.rd, cur.rw, cur.mr};
    end
    h2 = h1; h1 = hn;
    s_we = mem_we_o; s_re = mem_re_o; s_addr = mem_addr_o; s_wd = mem_wdata_o;
    @(posedge clk); #1;
    if (s_we) d_mem[s_addr[3:0]] = s_wd;
    junk = $urandom;
    mem_rdata_i = s_re ? d_mem[s_addr[3:0]] : junk[W-1:0];
    cyc++;
    if (acc || exp_tk || !cur_v) next_instr();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, inst_ready_o, 1'b1);
    chk({tag, "_br"}, br_taken_o, 1'b0);
    chk({tag, "_tgt"}, br_target_o, '0);
    chk({tag, "_we"}, mem_we_o, 1'b0);
    chk({tag, "_re"}, mem_re_o, 1'b0);
    chk({tag, "_addr"}, mem_addr_o, '0);
    chk({tag, "_wd"}, mem_wdata_o, '0);
    chk({tag, "_wbwe"}, wb_we_o, 1'b0);
    chk({tag, "_wba"}, W'(wb_addr_o), '0);
    chk({tag, "_wbd"}, wb_data_o, '0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = d_mem[i];
    q_wb.delete(); q_st.delete(); q_ld.delete(); q_br.delete();
    h1 = '{1'b0, '0, 1'b0, 1'b0};
    h2 = h1;
  endtask

  initial begin
    logic [31:0] r;
    bit seen;
    n_chk = 0; n_err = 0; cyc = 0;
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      d_mem[i] = r[W-1:0];
    end
    d_mem[4] = 16'h1234;
    mem_rdata_i = 16'h5A5A;
    model_reset();
    next_instr();
    inst_valid_i = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    next_instr();

    // Forwarding chain, load-use, taken branch, ALU edges, R0 writes
    dir_q.push_back(mk(3'd0, 1, 0, 0, 16'd5, 1, 1));
    dir_q.push_back(mk(3'd0, 2, 1, 1, 16'd0, 0, 1));
    begin
      instr_t t;
      t = mk(3'd0, 3, 0, 0, 16'd4, 1, 1); t.mr = 1'b1; dir_q.push_back(t);
      dir_q.push_back(mk(3'd0, 4, 3, 0, 16'd1, 1, 1));
      dir_q.push_back(mk(3'd0, 5, 0, 0, 16'd7, 1, 1));
      dir_q.push_back(mk(3'd0, 6, 0, 0, 16'd7, 1, 1));
      t = mk(3'd0, 0, 5, 6, 16'hFFFD, 0, 0); t.br = 1'b1; t.pc = 16'h0020; dir_q.push_back(t);
      dir_q.push_back(mk(3'd0, 7, 0, 0, 16'h0055, 1, 1));
      dir_q.push_back(mk(3'd0, 7, 0, 0, 16'h0001, 1, 1));
    end
    dir_q.push_back(mk(3'd0, 1, 0, 0, 16'hFFFF, 1, 1));
    dir_q.push_back(mk(3'd0, 2, 0, 0, 16'd1, 1, 1));
    dir_q.push_back(mk(3'd7, 4, 1, 2, 16'd0, 0, 1));
    dir_q.push_back(mk(3'd0, 5, 1, 0, 16'd1, 1, 1));
    dir_q.push_back(mk(3'd5, 6, 2, 0, 16'd17, 1, 1));
    dir_q.push_back(mk(3'd0, 0, 0, 0, 16'd9, 1, 1));
    dir_q.push_back(mk(3'd0, 1, 0, 0, 16'd0, 1, 1));
    for (int k = 0; k < 40; k++) step();

    // Reset while a store sits in EX
    begin
      instr_t t;
      t = mk(3'd0, 0, 0, 2, 16'd6, 1, 0); t.mw = 1'b1;
      dir_q.push_back(t);
    end
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step();
      seen = last_acc_mw;
    end
    chk("rst_store_issued", seen, 1'b1);
    rst_n = 1'b0;
    #2;
    chk_reset_outs("rst1");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mem_we", mem_we_o, 1'b0);
      chk("rst_wb_we", wb_we_o, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    next_instr();

    for (int k = 0; k < 3000; k++) step();
    for (int k = 0; k < 6; k++) begin
      dir_q.push_back(mk(3'd0, 0, 0, 0, 16'd0, 1, 0));
    end
    for (int k = 0; k < 10; k++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
